// File: rtl/sid_envelope.sv
// Per-voice SID ADSR envelope generator with wave*env amplitude stage.
// All envelope state advances on the 1 MHz SID cycle enable ce.
module sid_envelope #(
  parameter int unsigned RATE_W = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        gate,
  input  logic [3:0]  attack,
  input  logic [3:0]  decay,
  input  logic [3:0]  sustain,
  input  logic [3:0]  release_rate,
  input  logic [11:0] wave,
  output logic [7:0]  env,
  output logic [11:0] voice,
  output logic        voice_valid
);

  typedef enum logic [1:0] {
    ATTACK,
    DECAY_SUSTAIN,
    RELEASE
  } state_t;

  state_t            state, state_nxt;
  logic [RATE_W-1:0] rate_cnt, rate_nxt, rate_cmp;
  logic [4:0]        exp_cnt, exp_nxt, exp_per;
  logic [7:0]        env_nxt;
  logic              gate_q;
  logic [3:0]        idx;
  logic              tick, rise, fall, step_down;
  logic [19:0]       product;

  function automatic logic [14:0] rate_period(input logic [3:0] i);
    case (i)
      4'd0:    return 15'd8;
      4'd1:    return 15'd31;
      4'd2:    return 15'd62;
      4'd3:    return 15'd94;
      4'd4:    return 15'd148;
      4'd5:    return 15'd219;
      4'd6:    return 15'd266;
      4'd7:    return 15'd312;
      4'd8:    return 15'd391;
      4'd9:    return 15'd976;
      4'd10:   return 15'd1953;
      4'd11:   return 15'd3125;
      4'd12:   return 15'd3906;
      4'd13:   return 15'd11719;
      4'd14:   return 15'd19531;
      default: return 15'd31250;
    endcase
  endfunction

  always_comb begin
    case (state)
      ATTACK:        idx = attack;
      DECAY_SUSTAIN: idx = decay;
      default:       idx = release_rate;
    endcase
  end

  assign rate_cmp = RATE_W'(rate_period(idx));
  assign product  = 20'(wave) * 20'(env);

  always_comb begin
    if      (env > 8'h5D) exp_per = 5'd1;
    else if (env > 8'h36) exp_per = 5'd2;
    else if (env > 8'h1A) exp_per = 5'd4;
    else if (env > 8'h0E) exp_per = 5'd8;
    else if (env > 8'h06) exp_per = 5'd16;
    else if (env > 8'h00) exp_per = 5'd30;
    else                  exp_per = 5'd1;
  end

  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    exp_nxt   = exp_cnt;
    step_down = 1'b0;
    // Equality-only compare: a shorter rate selected past its period waits for the wrap.
    tick      = (rate_cnt == rate_cmp);
    rate_nxt  = tick ? '0 : rate_cnt + 1'b1;
    rise      = gate & ~gate_q;
    fall      = ~gate & gate_q;

    if (rise) begin
      state_nxt = ATTACK;
    end else if (fall) begin
      state_nxt = RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          if (env != 8'hFF) env_nxt = env + 8'd1;
          if (env >= 8'hFE) begin
            state_nxt = DECAY_SUSTAIN;
            exp_nxt   = '0;
          end
        end
        DECAY_SUSTAIN: step_down = (env != {sustain, sustain}) && (env != 8'h00);
        default:       step_down = (env != 8'h00);
      endcase
    end

    if (step_down) begin
      if (exp_cnt == exp_per - 5'd1) begin
        exp_nxt = '0;
        env_nxt = env - 8'd1;
      end else begin
        exp_nxt = exp_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RELEASE;
      env         <= '0;
      rate_cnt    <= '0;
      exp_cnt     <= '0;
      gate_q      <= 1'b0;
      voice       <= '0;
      voice_valid <= 1'b0;
    end else begin
      voice_valid <= ce;
      if (ce) begin
        state    <= state_nxt;
        env      <= env_nxt;
        rate_cnt <= rate_nxt;
        exp_cnt  <= exp_nxt;
        gate_q   <= gate;
        voice    <= product[19:8];
      end
    end
  end

endmodule
